axi_arbiter_2to1: RTL and testbench

- Arbitrates two AXI4 masters, IFU (read-only) and LSU (read/write), onto a single AXI4 master port.
- That port feeds the virtual-side (v_io_master_*) interface of the MMU.
- Only one transaction is in flight at a time, which matches the MMU's single-outstanding-request model.
- Grant selection is round-robin and registered, so every output valid is a mux of a registered grant and an input.

---
 rtl/axi_arbiter_2to1_pkg.sv | 17 +
 rtl/axi_arbiter_2to1.sv | 195 +++++++++++++++++++
 tb/tb_axi_arbiter_2to1.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_arbiter_2to1_pkg.sv
// Shared constants for the IFU/LSU to MMU AXI4 arbiter: FSM encoding,
// master indices and AXI response codes.
package axi_arbiter_2to1_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_IFU_RD = 2'd1;
    localparam logic [1:0] ST_LSU_RD = 2'd2;
    localparam logic [1:0] ST_LSU_WR = 2'd3;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_arbiter_2to1.sv
// Two-master AXI4 arbiter (IFU read-only, LSU read/write) onto the MMU's
// virtual-side port; one transaction in flight, round-robin on read ties.
module axi_arbiter_2to1
    import axi_arbiter_2to1_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic [ID_W-1:0]     ifu_arid,
    input  logic [7:0]          ifu_arlen,
    input  logic [2:0]          ifu_arsize,
    input  logic [1:0]          ifu_arburst,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    output logic [1:0]          ifu_rresp,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rlast,
    output logic [ID_W-1:0]     ifu_rid,

    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [ID_W-1:0]     lsu_arid,
    input  logic [7:0]          lsu_arlen,
    input  logic [2:0]          lsu_arsize,
    input  logic [1:0]          lsu_arburst,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    output logic [1:0]          lsu_rresp,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rlast,
    output logic [ID_W-1:0]     lsu_rid,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [ID_W-1:0]     lsu_awid,
    input  logic [7:0]          lsu_awlen,
    input  logic [2:0]          lsu_awsize,
    input  logic [1:0]          lsu_awburst,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wlast,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    output logic [1:0]          lsu_bresp,
    output logic [ID_W-1:0]     lsu_bid,

    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [ID_W-1:0]     m_arid,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [1:0]          m_rresp,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rlast,
    input  logic [ID_W-1:0]     m_rid,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [ID_W-1:0]     m_awid,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    input  logic [ID_W-1:0]     m_bid
);

    logic [1:0] state, state_nxt;
    logic       last_rd, last_rd_nxt;
    logic       gnt_ifu, gnt_lsu_rd, gnt_wr;

    // Writes win outright; read ties go to whoever did not read last.
    always_comb begin
        state_nxt   = state;
        last_rd_nxt = last_rd;
        case (state)
            ST_IDLE: begin
                if (lsu_awvalid) begin
                    state_nxt = ST_LSU_WR;
                end else if (ifu_arvalid && lsu_arvalid) begin
                    state_nxt   = (last_rd == MST_LSU) ? ST_IFU_RD : ST_LSU_RD;
                    last_rd_nxt = ~last_rd;
                end else if (ifu_arvalid) begin
                    state_nxt   = ST_IFU_RD;
                    last_rd_nxt = MST_IFU;
                end else if (lsu_arvalid) begin
                    state_nxt   = ST_LSU_RD;
                    last_rd_nxt = MST_LSU;
                end
            end
            ST_IFU_RD, ST_LSU_RD: begin
                if (m_rvalid && m_rready && m_rlast) state_nxt = ST_IDLE;
            end
            ST_LSU_WR: begin
                if (m_bvalid && m_bready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            last_rd <= MST_LSU;
        end else begin
            state   <= state_nxt;
            last_rd <= last_rd_nxt;
        end
    end

    assign gnt_ifu    = (state == ST_IFU_RD);
    assign gnt_lsu_rd = (state == ST_LSU_RD);
    assign gnt_wr     = (state == ST_LSU_WR);

    always_comb begin
        m_araddr  = '0;
        m_arid    = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        if (gnt_ifu) begin
            m_araddr  = ifu_araddr;
            m_arid    = ifu_arid;
            m_arlen   = ifu_arlen;
            m_arsize  = ifu_arsize;
            m_arburst = ifu_arburst;
        end else if (gnt_lsu_rd) begin
            m_araddr  = lsu_araddr;
            m_arid    = lsu_arid;
            m_arlen   = lsu_arlen;
            m_arsize  = lsu_arsize;
            m_arburst = lsu_arburst;
        end
    end

    assign m_arvalid   = (gnt_ifu & ifu_arvalid) | (gnt_lsu_rd & lsu_arvalid);
    assign ifu_arready = gnt_ifu & m_arready;
    assign lsu_arready = gnt_lsu_rd & m_arready;

    assign m_rready   = (gnt_ifu & ifu_rready) | (gnt_lsu_rd & lsu_rready);
    assign ifu_rvalid = gnt_ifu & m_rvalid;
    assign ifu_rresp  = m_rresp;
    assign ifu_rdata  = m_rdata;
    assign ifu_rlast  = m_rlast;
    assign ifu_rid    = m_rid;
    assign lsu_rvalid = gnt_lsu_rd & m_rvalid;
    assign lsu_rresp  = m_rresp;
    assign lsu_rdata  = m_rdata;
    assign lsu_rlast  = m_rlast;
    assign lsu_rid    = m_rid;

    assign m_awvalid   = gnt_wr & lsu_awvalid;
    assign m_awaddr    = gnt_wr ? lsu_awaddr  : '0;
    assign m_awid      = gnt_wr ? lsu_awid    : '0;
    assign m_awlen     = gnt_wr ? lsu_awlen   : '0;
    assign m_awsize    = gnt_wr ? lsu_awsize  : '0;
    assign m_awburst   = gnt_wr ? lsu_awburst : '0;
    assign lsu_awready = gnt_wr & m_awready;

    assign m_wvalid   = gnt_wr & lsu_wvalid;
    assign m_wdata    = gnt_wr ? lsu_wdata : '0;
    assign m_wstrb    = gnt_wr ? lsu_wstrb : '0;
    assign m_wlast    = gnt_wr & lsu_wlast;
    assign lsu_wready = gnt_wr & m_wready;

    assign m_bready   = gnt_wr & lsu_bready;
    assign lsu_bvalid = gnt_wr & m_bvalid;
    assign lsu_bresp  = m_bresp;
    assign lsu_bid    = m_bid;

    // A response with nothing outstanding means the MMU broke protocol.
    a_no_stray_resp: assert property (@(posedge clock) disable iff (reset)
        !((state == ST_IDLE) && (m_rvalid || m_bvalid)));

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Directed self-checking bench for axi_arbiter_2to1: reset, tie alternation,
// bursts, write handshakes, error passthrough and mid-transaction reset.
module tb_axi_arbiter_2to1;
    import axi_arbiter_2to1_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [3:0]  ifu_arid, ifu_rid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [3:0]  lsu_arid, lsu_rid;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_wlast;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_awid, lsu_wstrb, lsu_bid;
    logic [7:0]  lsu_awlen;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst, lsu_bresp;
    logic        lsu_bvalid, lsu_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [31:0] m_araddr, m_rdata;
    logic [3:0]  m_arid, m_rid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_awid, m_wstrb, m_bid;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst, m_bresp;
    logic        m_bvalid, m_bready;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    axi_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
        .ifu_arburst(ifu_arburst), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize),
        .lsu_arburst(lsu_arburst), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_rresp(lsu_rresp), .lsu_rdata(lsu_rdata), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
        .lsu_awid(lsu_awid), .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize),
        .lsu_awburst(lsu_awburst), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata),
        .m_rlast(m_rlast), .m_rid(m_rid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_bid(m_bid)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_quiet(input string tag);
        chk(tag, {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                  ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid,
                  lsu_awready, lsu_wready, lsu_bvalid}, 64'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Entered just after the grant edge; serves AR then 'beats' R beats.
    task automatic do_read(input logic mst, input int unsigned beats, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] resp);
        @(negedge clock);
        chk("ar_valid", m_arvalid, 1);
        chk("ar_addr", m_araddr, addr);
        chk("ar_len", m_arlen, beats - 1);
        chk("ar_ready_gnt", mst ? lsu_arready : ifu_arready, 1);
        chk("ar_ready_other", mst ? ifu_arready : lsu_arready, 0);
        cyc();
        if (mst) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
        for (int unsigned b = 0; b < beats; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = data + b;
            m_rlast  = (b == beats - 1);
            m_rresp  = resp;
            @(negedge clock);
            chk("r_valid", mst ? lsu_rvalid : ifu_rvalid, 1);
            chk("r_data", mst ? lsu_rdata : ifu_rdata, data + b);
            chk("r_resp", mst ? lsu_rresp : ifu_rresp, resp);
            chk("r_valid_other", mst ? ifu_rvalid : lsu_rvalid, 0);
            chk("ar_ready_other_beat", mst ? ifu_arready : lsu_arready, 0);
            chk("m_rready", m_rready, 1);
            cyc();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {ifu_arvalid, ifu_araddr, ifu_arid, ifu_arlen, ifu_arsize, ifu_arburst} = '0;
        {lsu_arvalid, lsu_araddr, lsu_arid, lsu_arlen, lsu_arsize, lsu_arburst} = '0;
        {lsu_awvalid, lsu_awaddr, lsu_awid, lsu_awlen, lsu_awsize, lsu_awburst} = '0;
        {lsu_wvalid, lsu_wdata, lsu_wstrb, lsu_wlast} = '0;
        {m_rvalid, m_rresp, m_rdata, m_rlast, m_rid} = '0;
        {m_bvalid, m_bresp, m_bid} = '0;
        ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1;
        m_arready  = 1'b1; m_awready  = 1'b1; m_wready   = 1'b1;

        do_reset();
        @(negedge clock);
        chk_all_quiet("reset_quiet");
        chk("reset_state", dut.state, ST_IDLE);

        // Simultaneous reads after reset: IFU, then LSU, then IFU again.
        cyc();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; ifu_arlen = 8'd0; ifu_arid = 4'h3;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h4000_0010; lsu_arlen = 8'd0; lsu_arid = 4'h5;
        @(negedge clock);
        chk("idle_no_arvalid", m_arvalid, 0);
        chk("idle_no_arready", {ifu_arready, lsu_arready}, 0);
        cyc();
        chk("tie1_ifu", dut.state, ST_IFU_RD);
        chk("tie1_arid", m_arid, 4'h3);
        do_read(MST_IFU, 1, 32'h8000_0000, 32'h1234_5678, RESP_OKAY);
        chk("tie1_exit_idle", dut.state, ST_IDLE);
        @(negedge clock);
        chk("exit_idle_lsu_wait", lsu_arready, 0);
        cyc();
        chk("tie2_lsu", dut.state, ST_LSU_RD);
        chk("tie2_arid", m_arid, 4'h5);
        do_read(MST_LSU, 1, 32'h4000_0010, 32'h0000_aaaa, RESP_OKAY);
        chk("tie2_exit_idle", dut.state, ST_IDLE);
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        cyc();
        chk("tie3_ifu", dut.state, ST_IFU_RD);
        do_read(MST_IFU, 1, 32'h8000_0000, 32'h0000_5555, RESP_OKAY);
        cyc();
        chk("tie3_then_lsu", dut.state, ST_LSU_RD);
        do_read(MST_LSU, 1, 32'h4000_0010, 32'hbad0_0000, RESP_SLVERR);
        chk("slverr_exit_idle", dut.state, ST_IDLE);

        // Arbitration continues normally after an error response.
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0040;
        cyc();
        chk("post_err_ifu", dut.state, ST_IFU_RD);
        do_read(MST_IFU, 1, 32'h8000_0040, 32'h0101_0101, RESP_OKAY);

        // 4-beat IFU burst holds the grant while an LSU read waits.
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0100; ifu_arlen = 8'd3;
        cyc();
        chk("burst_ifu", dut.state, ST_IFU_RD);
        lsu_arvalid = 1'b1; lsu_araddr = 32'h4000_0080;
        do_read(MST_IFU, 4, 32'h8000_0100, 32'hc000_0000, RESP_OKAY);
        chk("burst_exit_idle", dut.state, ST_IDLE);
        ifu_arlen = 8'd0;
        cyc();
        chk("burst_then_lsu", dut.state, ST_LSU_RD);
        do_read(MST_LSU, 1, 32'h4000_0080, 32'h7777_0000, RESP_OKAY);

        // LSU write with W presented two cycles before AW.
        lsu_wvalid = 1'b1; lsu_wdata = 32'hdead_beef; lsu_wstrb = 4'hf; lsu_wlast = 1'b1;
        @(negedge clock);
        chk("w_early_blocked", {lsu_wready, m_wvalid}, 0);
        cyc();
        @(negedge clock);
        chk("w_early_still_idle", dut.state, ST_IDLE);
        cyc();
        lsu_awvalid = 1'b1; lsu_awaddr = 32'ha000_03f8; lsu_awid = 4'h9; lsu_awlen = 8'd0;
        @(negedge clock);
        chk("aw_idle_blocked", m_awvalid, 0);
        cyc();
        chk("wr_grant", dut.state, ST_LSU_WR);
        @(negedge clock);
        chk("m_awvalid", m_awvalid, 1);
        chk("m_awaddr", m_awaddr, 32'ha000_03f8);
        chk("m_awid", m_awid, 4'h9);
        chk("m_wvalid", m_wvalid, 1);
        chk("m_wdata", m_wdata, 32'hdead_beef);
        chk("m_wstrb", m_wstrb, 4'hf);
        chk("aw_w_ready", {lsu_awready, lsu_wready}, 2'b11);
        chk("wr_ifu_blocked", ifu_arready, 0);
        cyc();
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        m_bvalid = 1'b1; m_bresp = RESP_OKAY; m_bid = 4'h9; lsu_bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("b_valid_held", lsu_bvalid, 1);
            chk("b_ready_low", m_bready, 0);
            chk("b_wait_state", dut.state, ST_LSU_WR);
            cyc();
        end
        lsu_bready = 1'b1;
        @(negedge clock);
        chk("b_handshake", {lsu_bvalid, m_bready, lsu_bresp, lsu_bid}, {1'b1, 1'b1, RESP_OKAY, 4'h9});
        cyc();
        m_bvalid = 1'b0;
        chk("wr_exit_idle", dut.state, ST_IDLE);

        // Reset in the middle of an LSU read with a beat pending.
        lsu_arvalid = 1'b1; lsu_araddr = 32'h4000_0020;
        cyc();
        chk("rst_lsu_grant", dut.state, ST_LSU_RD);
        cyc();
        lsu_arvalid = 1'b0;
        m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = 32'h5a5a_5a5a;
        @(negedge clock);
        chk("rst_pre_rvalid", lsu_rvalid, 1);
        reset = 1'b1;
        cyc();
        chk_all_quiet("midtxn_reset_quiet");
        chk("midtxn_reset_state", dut.state, ST_IDLE);
        m_rvalid = 1'b0;
        reset = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0200;
        cyc();
        chk("post_rst_ifu", dut.state, ST_IFU_RD);
        do_read(MST_IFU, 1, 32'h8000_0200, 32'h0bad_cafe, RESP_OKAY);
        chk("final_idle", dut.state, ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
